// File: rtl/scaler_quantizer.sv
// Quantizer stage: selects a bit window from a signed product, clamps it to cfg_prec bits
// and streams the result MSB first. Define SCALER_QUANT_ROUND_EN for round-half-up.
module scaler_quantizer #(
  parameter int unsigned BP = 48,
  parameter int unsigned BQ = 16,
  parameter int unsigned BW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] cfg_msbidx,
  input  logic [4:0]    cfg_prec,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BP-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic          sat_flag,
  input  logic          clr_sat
);

  localparam int unsigned PW = 5;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t               state;
  logic [BP-1:0]        data_q;
  logic [BW-1:0]        msb_q;
  logic [PW-1:0]        prec_q;
  logic [BQ-1:0]        sh_q;
  logic [PW-1:0]        cnt_q;

  logic [PW-1:0]        prec_clamp_c;
  logic [BW-1:0]        lsb_c;
  logic signed [BP:0]   ext_c;
  logic signed [BP:0]   shifted_c;
  logic signed [BP:0]   v_c;
  logic signed [BP:0]   pmax_c;
  logic signed [BP:0]   pmin_c;
  logic signed [BP:0]   clamp_c;
  logic                 sat_c;
  logic [BQ-1:0]        aligned_c;

  // Precision 0 behaves as 1, anything above BQ behaves as BQ.
  always_comb begin
    prec_clamp_c = cfg_prec;
    if (cfg_prec == '0) begin
      prec_clamp_c = PW'(1);
    end else if (cfg_prec > PW'(BQ)) begin
      prec_clamp_c = PW'(BQ);
    end
  end

  // Window select, optional rounding, clamp, then left-align the P-bit word for shifting.
  always_comb begin
    ext_c     = {data_q[BP-1], data_q};
    lsb_c     = '0;
    if (msb_q >= BW'(prec_q - PW'(1))) begin
      lsb_c = msb_q - BW'(prec_q - PW'(1));
    end
    shifted_c = ext_c >>> lsb_c;
`ifdef SCALER_QUANT_ROUND_EN
    v_c = shifted_c;
    if (lsb_c != '0) begin
      v_c = shifted_c + (BP+1)'(1'(ext_c >>> (lsb_c - BW'(1))));
    end
`else
    v_c = shifted_c;
`endif
    pmax_c    = ((BP+1)'(1) << (prec_q - PW'(1))) - (BP+1)'(1);
    pmin_c    = ~pmax_c;
    clamp_c   = v_c;
    sat_c     = 1'b0;
    if (v_c > pmax_c) begin
      clamp_c = pmax_c;
      sat_c   = 1'b1;
    end else if (v_c < pmin_c) begin
      clamp_c = pmin_c;
      sat_c   = 1'b1;
    end
    aligned_c = BQ'(clamp_c) << (PW'(BQ) - prec_q);
  end

  // Control FSM with registered handshake and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      data_q    <= '0;
      msb_q     <= '0;
      prec_q    <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            msb_q    <= cfg_msbidx;
            prec_q   <= prec_clamp_c;
            in_ready <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          sh_q      <= aligned_c << 1;
          cnt_q     <= prec_q - PW'(1);
          out_valid <= 1'b1;
          out_bit   <= aligned_c[BQ-1];
          out_last  <= (prec_q == PW'(1));
          state     <= SHIFT;
        end
        SHIFT: begin
          if (out_ready) begin
            if (cnt_q == '0) begin
              out_valid <= 1'b0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              out_bit  <= sh_q[BQ-1];
              sh_q     <= sh_q << 1;
              cnt_q    <= cnt_q - PW'(1);
              out_last <= (cnt_q == PW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky saturation flag; a new saturation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (state == LOAD && sat_c) begin
      sat_flag <= 1'b1;
    end else if (clr_sat) begin
      sat_flag <= 1'b0;
    end
  end

endmodule
